// File: rtl/nf10_rr_input_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : nf10_rr_input_arbiter_if
// Description : Bus bundle for the five-input round-robin AXI4-Stream merger.
//               Carries the five slave streams (s_axis_*_0..4), the merged
//               master stream (m_axis_*), and the per-packet stats outputs
//               (pkt_fwd one-hot source pulse, bytes_fwd packet length).
//               Modport 'slave' is the arbiter's view: it consumes the
//               s_axis streams and produces the m_axis stream.
//               Modport 'master' is the surrounding environment's view:
//               it feeds the s_axis streams and sinks the m_axis stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface nf10_rr_input_arbiter_if #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int NUM_INPUTS           = 5
);
    logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, s_axis_tdata_4;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3, s_axis_tstrb_4;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3, s_axis_tuser_4;
    logic s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2, s_axis_tvalid_3, s_axis_tvalid_4;
    logic s_axis_tready_0, s_axis_tready_1, s_axis_tready_2, s_axis_tready_3, s_axis_tready_4;
    logic s_axis_tlast_0,  s_axis_tlast_1,  s_axis_tlast_2,  s_axis_tlast_3,  s_axis_tlast_4;

    logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser;
    logic                             m_axis_tvalid;
    logic                             m_axis_tready;
    logic                             m_axis_tlast;

    logic [NUM_INPUTS-1:0]            pkt_fwd;
    logic [C_S_AXI_DATA_WIDTH-1:0]    bytes_fwd;

    modport slave (
        input  s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, s_axis_tdata_4,
        input  s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3, s_axis_tstrb_4,
        input  s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3, s_axis_tuser_4,
        input  s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2, s_axis_tvalid_3, s_axis_tvalid_4,
        output s_axis_tready_0, s_axis_tready_1, s_axis_tready_2, s_axis_tready_3, s_axis_tready_4,
        input  s_axis_tlast_0, s_axis_tlast_1, s_axis_tlast_2, s_axis_tlast_3, s_axis_tlast_4,
        output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output pkt_fwd, bytes_fwd
    );

    modport master (
        output s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, s_axis_tdata_4,
        output s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3, s_axis_tstrb_4,
        output s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3, s_axis_tuser_4,
        output s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2, s_axis_tvalid_3, s_axis_tvalid_4,
        input  s_axis_tready_0, s_axis_tready_1, s_axis_tready_2, s_axis_tready_3, s_axis_tready_4,
        output s_axis_tlast_0, s_axis_tlast_1, s_axis_tlast_2, s_axis_tlast_3, s_axis_tlast_4,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  pkt_fwd, bytes_fwd
    );
endinterface
`default_nettype wire

// File: rtl/nf10_rr_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nf10_rr_input_arbiter
// Description : Packet-granular round-robin merger of five AXI4-Stream inputs
//               into one AXI4-Stream output. Each input owns a small
//               fall-through FIFO; once a packet starts it is forwarded to
//               completion before the grant moves on, so beats of different
//               packets are never interleaved.
// Ports       : axi_aclk  - clock, all logic on the rising edge
//               axi_reset - synchronous active-high reset (flushes FIFOs)
//               axis      - bus bundle (slave modport): five s_axis inputs,
//                           merged m_axis output, pkt_fwd/bytes_fwd stats
// Revision    : 1.0 - initial release
// ============================================================================
module nf10_rr_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int NUM_INPUTS           = 5,
    parameter int IN_FIFO_DEPTH_BITS   = 2
) (
    input  wire logic               axi_aclk,
    input  wire logic               axi_reset,
    nf10_rr_input_arbiter_if.slave  axis
);
    localparam int c_dw     = C_S_AXIS_DATA_WIDTH;
    localparam int c_sw     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int c_uw     = C_S_AXIS_TUSER_WIDTH;
    localparam int c_word_w = 1 + c_uw + c_sw + c_dw;     // {tlast, tuser, tstrb, tdata}
    localparam int c_depth  = 1 << IN_FIFO_DEPTH_BITS;
    localparam int c_cur_w  = $clog2(NUM_INPUTS);
    // tready drops one entry early so a beat already in flight never overflows.
    localparam logic [IN_FIFO_DEPTH_BITS:0] c_nearly_full = (IN_FIFO_DEPTH_BITS+1)'(c_depth - 1);
    localparam logic [c_cur_w-1:0]          c_last_in     = c_cur_w'(NUM_INPUTS - 1);

    typedef enum logic [0:0] {
        PKT_START = 1'b0,
        PKT_BODY  = 1'b1
    } state_t;

    logic [c_word_w-1:0]   w_in_word [NUM_INPUTS];
    logic [c_word_w-1:0]   w_head    [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] w_in_valid;
    logic [NUM_INPUTS-1:0] w_in_ready;
    logic [NUM_INPUTS-1:0] w_empty;
    logic [NUM_INPUTS-1:0] w_pop;

    logic [c_word_w-1:0]   w_sel;
    logic                  w_sel_empty;
    logic                  w_xfer;
    logic                  w_sel_last;
    logic [c_uw-1:0]       w_sel_user;
    logic [c_cur_w-1:0]    w_cur_next;

    state_t                          r_state;
    logic [c_cur_w-1:0]              r_cur;
    logic [NUM_INPUTS-1:0]           r_pkt_fwd;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_bytes_fwd;

    // ------------------------------------------------------------------
    // Flatten the named per-input ports into indexable arrays
    // ------------------------------------------------------------------
    assign w_in_word[0] = {axis.s_axis_tlast_0, axis.s_axis_tuser_0, axis.s_axis_tstrb_0, axis.s_axis_tdata_0};
    assign w_in_word[1] = {axis.s_axis_tlast_1, axis.s_axis_tuser_1, axis.s_axis_tstrb_1, axis.s_axis_tdata_1};
    assign w_in_word[2] = {axis.s_axis_tlast_2, axis.s_axis_tuser_2, axis.s_axis_tstrb_2, axis.s_axis_tdata_2};
    assign w_in_word[3] = {axis.s_axis_tlast_3, axis.s_axis_tuser_3, axis.s_axis_tstrb_3, axis.s_axis_tdata_3};
    assign w_in_word[4] = {axis.s_axis_tlast_4, axis.s_axis_tuser_4, axis.s_axis_tstrb_4, axis.s_axis_tdata_4};

    assign w_in_valid = {axis.s_axis_tvalid_4, axis.s_axis_tvalid_3, axis.s_axis_tvalid_2,
                         axis.s_axis_tvalid_1, axis.s_axis_tvalid_0};

    assign axis.s_axis_tready_0 = w_in_ready[0];
    assign axis.s_axis_tready_1 = w_in_ready[1];
    assign axis.s_axis_tready_2 = w_in_ready[2];
    assign axis.s_axis_tready_3 = w_in_ready[3];
    assign axis.s_axis_tready_4 = w_in_ready[4];

    // ------------------------------------------------------------------
    // Per-input fall-through FIFOs: the head entry is read directly from
    // storage, so a beat written on one edge is presented right after it.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_fifo
        logic [c_word_w-1:0]           r_mem [c_depth];
        logic [IN_FIFO_DEPTH_BITS-1:0] r_wr_ptr;
        logic [IN_FIFO_DEPTH_BITS-1:0] r_rd_ptr;
        logic [IN_FIFO_DEPTH_BITS:0]   r_count;
        logic                          w_wr;

        assign w_in_ready[i] = (r_count < c_nearly_full);
        assign w_wr          = w_in_valid[i] & w_in_ready[i];
        assign w_empty[i]    = (r_count == '0);
        assign w_head[i]     = r_mem[r_rd_ptr];

        // Storage is not reset; flushing the pointers is enough to discard it.
        always_ff @(posedge axi_aclk) begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_in_word[i];
            end
        end

        always_ff @(posedge axi_aclk) begin
            if (axi_reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_wr, w_pop[i]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mux from the granted FIFO head
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = '0;
        w_sel_empty = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (r_cur == c_cur_w'(k)) begin
                w_sel       = w_head[k];
                w_sel_empty = w_empty[k];
            end
        end
    end

    assign w_xfer     = ~w_sel_empty & axis.m_axis_tready;
    assign w_sel_last = w_sel[c_word_w-1];
    assign w_sel_user = w_sel[c_dw+c_sw +: c_uw];
    assign w_cur_next = (r_cur == c_last_in) ? '0 : r_cur + c_cur_w'(1);

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (r_cur == c_cur_w'(k)) begin
                w_pop[k] = w_xfer;
            end
        end
    end

    assign axis.m_axis_tdata  = w_sel[c_dw-1:0];
    assign axis.m_axis_tstrb  = w_sel[c_dw +: c_sw];
    assign axis.m_axis_tuser  = w_sel_user;
    assign axis.m_axis_tlast  = w_sel_last;
    assign axis.m_axis_tvalid = ~w_sel_empty;
    assign axis.pkt_fwd       = r_pkt_fwd;
    assign axis.bytes_fwd     = r_bytes_fwd;

    // ------------------------------------------------------------------
    // Grant state machine and per-packet stats
    // ------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state     <= PKT_START;
            r_cur       <= '0;
            r_pkt_fwd   <= '0;
            r_bytes_fwd <= '0;
        end else begin
            r_pkt_fwd   <= '0;
            r_bytes_fwd <= '0;
            case (r_state)
                PKT_START: begin
                    if (w_sel_empty) begin
                        // Idle input: look at the next one on the following cycle.
                        r_cur <= w_cur_next;
                    end else if (w_xfer) begin
                        r_pkt_fwd   <= NUM_INPUTS'(1) << r_cur;
                        r_bytes_fwd <= C_S_AXI_DATA_WIDTH'(w_sel_user[15:0]);
                        if (w_sel_last) begin
                            r_cur <= w_cur_next;
                        end else begin
                            r_state <= PKT_BODY;
                        end
                    end
                end
                PKT_BODY: begin
                    // Grant is held through source gaps until the last beat leaves.
                    if (w_xfer && w_sel_last) begin
                        r_cur   <= w_cur_next;
                        r_state <= PKT_START;
                    end
                end
                default: begin
                    r_state <= PKT_START;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nf10_rr_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nf10_rr_input_arbiter
// Description : Directed self-checking bench for nf10_rr_input_arbiter.
//               Every beat carries a tdata/tstrb/tuser pattern derived from
//               (source, packet id, beat index) so ordering, loss and
//               duplication are visible in the data itself.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nf10_rr_input_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    nf10_rr_input_arbiter_if bus ();

    nf10_rr_input_arbiter dut (
        .axi_aclk  (clk),
        .axi_reset (rst),
        .axis      (bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] mk_data(input int src, input int id, input int beat);
        logic [31:0] w;
        w = {8'(src), 8'(id), 16'(beat)};
        return {8{w}};
    endfunction

    function automatic logic [31:0] mk_strb(input int src, input int id, input int beat);
        return {8'(beat), 8'(id), 8'(src), 8'hA5};
    endfunction

    function automatic logic [127:0] mk_user(input int id, input logic [15:0] len);
        return {96'h0, 8'h5A, 8'(id), len};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input int i, input logic v, input logic [255:0] d, input logic [31:0] s,
                          input logic [127:0] u, input logic l);
        case (i)
            0: begin bus.s_axis_tvalid_0 = v; bus.s_axis_tdata_0 = d; bus.s_axis_tstrb_0 = s; bus.s_axis_tuser_0 = u; bus.s_axis_tlast_0 = l; end
            1: begin bus.s_axis_tvalid_1 = v; bus.s_axis_tdata_1 = d; bus.s_axis_tstrb_1 = s; bus.s_axis_tuser_1 = u; bus.s_axis_tlast_1 = l; end
            2: begin bus.s_axis_tvalid_2 = v; bus.s_axis_tdata_2 = d; bus.s_axis_tstrb_2 = s; bus.s_axis_tuser_2 = u; bus.s_axis_tlast_2 = l; end
            3: begin bus.s_axis_tvalid_3 = v; bus.s_axis_tdata_3 = d; bus.s_axis_tstrb_3 = s; bus.s_axis_tuser_3 = u; bus.s_axis_tlast_3 = l; end
            default: begin bus.s_axis_tvalid_4 = v; bus.s_axis_tdata_4 = d; bus.s_axis_tstrb_4 = s; bus.s_axis_tuser_4 = u; bus.s_axis_tlast_4 = l; end
        endcase
    endtask

    function automatic logic get_rdy(input int i);
        case (i)
            0:       return bus.s_axis_tready_0;
            1:       return bus.s_axis_tready_1;
            2:       return bus.s_axis_tready_2;
            3:       return bus.s_axis_tready_3;
            default: return bus.s_axis_tready_4;
        endcase
    endfunction

    // Align to just after a rising edge, where all stimulus is applied.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer beats [first, first+cnt) of a total-beat packet on input i,
    // honouring s_axis_tready; called just after a rising edge.
    task automatic send_beats(input int i, input int id, input int first, input int cnt,
                              input int tot, input logic [15:0] len);
        for (int b = first; b < first + cnt; b++) begin
            logic acc;
            int   guard;
            acc   = 1'b0;
            guard = 0;
            set_in(i, 1'b1, mk_data(i, id, b), mk_strb(i, id, b), mk_user(id, len), (b == tot - 1));
            while (!acc && guard < 300) begin
                @(negedge clk);
                acc = get_rdy(i);
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) chk($sformatf("send_in%0d_id%0d_b%0d_accept", i, id, b), acc, 1'b1);
        end
        set_in(i, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Wait (bounded) for the next output transfer and check it, then check
    // the stats pulse registered by that transfer. Returns just after the
    // rising edge that completed the transfer.
    task automatic expect_beat(input string tag, input int src, input int id, input int beat,
                               input logic last, input logic first, input logic [15:0] len,
                               input int limit);
        int         n;
        logic       got;
        logic [4:0] exp_pkt;
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(negedge clk);
            n++;
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) got = 1'b1;
        end
        chk({tag, "_seen"}, got, 1'b1);
        if (got) begin
            chk({tag, "_tdata"}, bus.m_axis_tdata, mk_data(src, id, beat));
            chk({tag, "_tstrb"}, bus.m_axis_tstrb, mk_strb(src, id, beat));
            chk({tag, "_tuser"}, bus.m_axis_tuser, mk_user(id, len));
            chk({tag, "_tlast"}, bus.m_axis_tlast, last);
            @(posedge clk);
            #1;
            exp_pkt = first ? (5'b00001 << src) : 5'b00000;
            chk({tag, "_pkt_fwd"}, bus.pkt_fwd, exp_pkt);
            chk({tag, "_bytes_fwd"}, bus.bytes_fwd, first ? {16'h0000, len} : 32'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) set_in(k, 1'b0, '0, '0, '0, 1'b0);
        bus.m_axis_tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("reset_pkt_fwd", bus.pkt_fwd, 5'b00000);
        chk("reset_bytes_fwd", bus.bytes_fwd, 32'h0);
        chk("reset_s_tready", {bus.s_axis_tready_4, bus.s_axis_tready_3, bus.s_axis_tready_2,
                               bus.s_axis_tready_1, bus.s_axis_tready_0}, 5'b11111);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Step 1: 3-beat packet on input 2, tuser length 0x00C0.
        sync();
        fork
            send_beats(2, 1, 0, 3, 3, 16'h00C0);
            begin
                expect_beat("t1_b0", 2, 1, 0, 1'b0, 1'b1, 16'h00C0, 20);
                expect_beat("t1_b1", 2, 1, 1, 1'b0, 1'b0, 16'h00C0, 5);
                expect_beat("t1_b2", 2, 1, 2, 1'b1, 1'b0, 16'h00C0, 5);
            end
        join

        // Step 2: park grant on input 4, then inputs 0 and 1 each load a
        // 2-beat packet in the same cycles; output must not interleave.
        sync();
        bus.m_axis_tready = 1'b0;
        send_beats(4, 2, 0, 1, 1, 16'h0011);
        repeat (6) @(negedge clk);
        chk("t2_parked_tvalid", bus.m_axis_tvalid, 1'b1);
        sync();
        fork
            send_beats(0, 3, 0, 2, 2, 16'h0040);
            send_beats(1, 4, 0, 2, 2, 16'h0041);
        join
        sync();
        bus.m_axis_tready = 1'b1;
        expect_beat("t2_dummy", 4, 2, 0, 1'b1, 1'b1, 16'h0011, 3);
        expect_beat("t2_a0",    0, 3, 0, 1'b0, 1'b1, 16'h0040, 1);
        expect_beat("t2_a1",    0, 3, 1, 1'b1, 1'b0, 16'h0040, 1);
        expect_beat("t2_b0",    1, 4, 0, 1'b0, 1'b1, 16'h0041, 1);
        expect_beat("t2_b1",    1, 4, 1, 1'b1, 1'b0, 16'h0041, 1);

        // Step 3: backpressure while input 3 offers a 6-beat packet.
        sync();
        bus.m_axis_tready = 1'b0;
        fork
            send_beats(3, 5, 0, 6, 6, 16'h00C8);
            begin
                repeat (8) @(negedge clk);
                chk("t3_s_tready3_low", bus.s_axis_tready_3, 1'b0);
                chk("t3_tvalid_held", bus.m_axis_tvalid, 1'b1);
                chk("t3_tdata_beat0", bus.m_axis_tdata, mk_data(3, 5, 0));
                @(negedge clk);
                chk("t3_tdata_frozen", bus.m_axis_tdata, mk_data(3, 5, 0));
                chk("t3_tlast_frozen", bus.m_axis_tlast, 1'b0);
                @(posedge clk);
                #1;
                bus.m_axis_tready = 1'b1;
                for (int b = 0; b < 6; b++)
                    expect_beat($sformatf("t3_b%0d", b), 3, 5, b, (b == 5), (b == 0), 16'h00C8, 20);
            end
        join
        repeat (3) @(negedge clk);
        chk("t3_drained_tvalid", bus.m_axis_tvalid, 1'b0);

        // Step 4: wrap from input 4 to input 0 after a packet on input 3.
        sync();
        bus.m_axis_tready = 1'b0;
        send_beats(3, 6, 0, 1, 1, 16'h0020);
        repeat (6) @(negedge clk);
        chk("t4_parked_tdata", bus.m_axis_tdata, mk_data(3, 6, 0));
        sync();
        fork
            send_beats(4, 7, 0, 1, 1, 16'h0021);
            send_beats(0, 8, 0, 1, 1, 16'h0022);
        join
        sync();
        bus.m_axis_tready = 1'b1;
        expect_beat("t4_in3", 3, 6, 0, 1'b1, 1'b1, 16'h0020, 3);
        expect_beat("t4_in4", 4, 7, 0, 1'b1, 1'b1, 16'h0021, 1);
        expect_beat("t4_in0", 0, 8, 0, 1'b1, 1'b1, 16'h0022, 1);

        // Step 5: every input holds single-beat packets; strict rotation,
        // one packet per cycle, starting from input 0.
        sync();
        bus.m_axis_tready = 1'b0;
        send_beats(0, 16, 0, 1, 1, 16'd100);
        repeat (6) @(negedge clk);
        chk("t5_parked_tdata", bus.m_axis_tdata, mk_data(0, 16, 0));
        sync();
        fork
            for (int k = 1; k < 3; k++) send_beats(0, 16 + k, 0, 1, 1, 16'(100 + k));
            for (int k = 0; k < 3; k++) send_beats(1, 16 + k, 0, 1, 1, 16'(110 + k));
            for (int k = 0; k < 3; k++) send_beats(2, 16 + k, 0, 1, 1, 16'(120 + k));
            for (int k = 0; k < 3; k++) send_beats(3, 16 + k, 0, 1, 1, 16'(130 + k));
            for (int k = 0; k < 3; k++) send_beats(4, 16 + k, 0, 1, 1, 16'(140 + k));
        join
        sync();
        bus.m_axis_tready = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 5; s++)
                expect_beat($sformatf("t5_r%0d_s%0d", r, s), s, 16 + r, 0, 1'b1, 1'b1,
                            16'(100 + 10 * s + r), (r == 0 && s == 0) ? 3 : 1);

        // Step 6: reset pulse after beat 1 of a 4-beat packet on input 1.
        sync();
        fork
            send_beats(1, 40, 0, 2, 4, 16'h0100);
            begin
                expect_beat("t6_b0", 1, 40, 0, 1'b0, 1'b1, 16'h0100, 20);
                expect_beat("t6_b1", 1, 40, 1, 1'b0, 1'b0, 16'h0100, 5);
            end
        join
        sync();
        set_in(1, 1'b1, mk_data(1, 40, 2), mk_strb(1, 40, 2), mk_user(40, 16'h0100), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_rst_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("t6_rst_pkt_fwd", bus.pkt_fwd, 5'b00000);
        chk("t6_rst_bytes_fwd", bus.bytes_fwd, 32'h0);
        chk("t6_rst_s_tready", {bus.s_axis_tready_4, bus.s_axis_tready_3, bus.s_axis_tready_2,
                                bus.s_axis_tready_1, bus.s_axis_tready_0}, 5'b11111);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1, 1'b0, '0, '0, '0, 1'b0);
        repeat (6) @(negedge clk);
        chk("t6_post_rst_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("t6_post_rst_pkt_fwd", bus.pkt_fwd, 5'b00000);
        sync();
        fork
            send_beats(0, 41, 0, 2, 2, 16'h0080);
            begin
                expect_beat("t6_new_b0", 0, 41, 0, 1'b0, 1'b1, 16'h0080, 20);
                expect_beat("t6_new_b1", 0, 41, 1, 1'b1, 1'b0, 16'h0080, 5);
            end
        join
        repeat (3) @(negedge clk);
        chk("t6_final_tvalid", bus.m_axis_tvalid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nf10_rr_input_arbiter.md
Name: nf10_rr_input_arbiter

Overview:
- Packet-granular round-robin merger of NUM_INPUTS AXI4-Stream slave interfaces (MAC/DMA RX paths) into one AXI4-Stream master toward the datapath (output port lookup, then output queues).
- Each input has a small fall-through FIFO.
- A packet, once started, is forwarded to completion before the grant moves; beats from different packets are never interleaved.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (C_S_AXIS_DATA_WIDTH must be equal).
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width (C_S_AXIS_TUSER_WIDTH must be equal).
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; bits [15:0] carry packet length in bytes.
- C_S_AXI_DATA_WIDTH, 32, stats counter width.
- NUM_INPUTS, 5, number of slave interfaces; fixed at 5 by port list.
- IN_FIFO_DEPTH_BITS, 2, log2 of per-input FIFO depth (4 entries).

Ports:
- axi_aclk  in  1  sole clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata_0..4  in  C_S_AXIS_DATA_WIDTH each  input data.
- s_axis_tstrb_0..4  in  C_S_AXIS_DATA_WIDTH/8 each  byte strobes.
- s_axis_tuser_0..4  in  C_S_AXIS_TUSER_WIDTH each  metadata, valid on first beat.
- s_axis_tvalid_0..4  in  1 each  beat valid.
- s_axis_tready_0..4  out  1 each  = ~nearly_full of that input FIFO.
- s_axis_tlast_0..4  in  1 each  last beat of packet.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  strobes.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  tuser of the granted FIFO head.
- m_axis_tvalid  out  1  = ~empty of granted FIFO.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat.
- pkt_fwd  out  NUM_INPUTS  one-cycle one-hot pulse per packet forwarded, bit = source input.
- bytes_fwd  out  C_S_AXI_DATA_WIDTH  tuser[15:0] of that packet (zero-extended) during the pulse, else 0.

Behaviour:
- Input FIFO i:
  - Writes on s_axis_tvalid_i & s_axis_tready_i; stores {tlast, tuser, tstrb, tdata}.
  - Fall-through: a beat written at edge N is visible at its head after that edge. Minimum input-to-output latency is 1 cycle.
  - nearly_full asserts at ≥3 entries; a full FIFO is never written.
- Grant pointer cur (log2 NUM_INPUTS bits, reset 0). next(cur) = cur+1, wrapping from NUM_INPUTS-1 to 0.
- State machine (reset PKT_START):
  - PKT_START, FIFO[cur] empty: m_axis_tvalid=0; cur<=next(cur) each cycle (scan one input per cycle).
  - PKT_START, FIFO[cur] non-empty: m_axis_tvalid=1. On transfer (tvalid&tready):
    - tlast=1 (single beat): cur<=next(cur), stay in PKT_START.
    - else: go to PKT_BODY.
  - PKT_BODY: cur held; m_axis_tvalid=~empty[cur]. Gaps in the source packet stall the output and the grant does not move. On a transfer with tlast=1: cur<=next(cur), go to PKT_START.
- Master outputs are muxed from the head of FIFO[cur]. tvalid is independent of tready. While tvalid&~tready, all m_axis signals stay stable. A FIFO is popped only on a transfer.
- Stats:
  - pkt_fwd and bytes_fwd are registered and asserted in the cycle after a first-beat transfer (a transfer in PKT_START).
  - Back-to-back single-beat packets give consecutive pulses.
- Reset (including mid-packet):
  - All FIFOs are flushed and partial packets discarded.
  - state=PKT_START, cur=0; pkt_fwd=0, bytes_fwd=0.
  - m_axis_tvalid=0 and s_axis_tready_i=1 from the first edge sampling axi_reset=1 until the first edge after deassertion.
- Simultaneous events:
  - A write and a read of the same FIFO in one cycle are both performed; occupancy is unchanged.
  - An input write arriving while cur is pointed elsewhere waits for the pointer to come round.

Test Plan:
- Input 2: 3-beat packet, tuser[15:0]=0x00C0, m_axis_tready=1 -> 3 beats on m_axis in order, tlast on beat 3 only; next cycle pkt_fwd=5'b00100, bytes_fwd=0x000000C0.
- Inputs 0 and 1 each send a 2-beat packet in the same cycle -> output is A0,A1(tlast),B0,B1(tlast) with no interleave; pkt_fwd pulses 00001 then 00010.
- m_axis_tready=0 while input 3 sends 6 beats -> s_axis_tready_3 drops after 3 accepted beats; m_axis_tvalid=1 with tdata frozen on beat 0. On releasing tready, all 6 beats arrive in order, no loss or duplication.
- cur=4: 1-beat packets present on inputs 4 and 0 -> order is input 4 then input 0 (wrap); pkt_fwd 10000 then 00001.
- All 5 inputs continuously offer 1-beat packets -> output source sequence 0,1,2,3,4,0,1,... (one per cycle with tready=1).
- axi_reset pulsed for 1 cycle after beat 2 of a 4-beat packet on input 1 -> remaining beats never appear; m_axis_tvalid=0 and pkt_fwd=0 after reset. A new packet on input 0 is then forwarded normally.
